// File: rtl/conv3x3_stream_param.sv
// Purpose : 3x3 convolution over a buffered IFM frame with configurable size, stride, zero padding and signedness.
// Latency : a window issued in COMPUTE appears on Out_OFM five cycles later; one result per cycle.
// Backpressure: in_ready drops once the frame is full and while busy; results cannot be stalled downstream.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   weight_valid, In_Weight_1  kernel weights w0..w8, row-major
//   in_valid, In_IFM_1         IFM pixels in raster order; accepted while in_ready is high
//   in_ready                   LOAD state and frame buffer not yet full
//   out_valid, Out_OFM         result stream, raster order over OW x OH; Out_OFM is zero when idle
//   busy                       high in COMPUTE and DRAIN
module conv3x3_stream_param #(
    parameter int DW     = 16,
    parameter int IFM_W  = 7,
    parameter int IFM_H  = 7,
    parameter int STRIDE = 1,
    parameter int PAD    = 0,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              weight_valid,
    input  logic [DW-1:0]     In_Weight_1,
    input  logic              in_valid,
    input  logic [DW-1:0]     In_IFM_1,
    output logic              in_ready,
    output logic              out_valid,
    output logic [2*DW+3:0]   Out_OFM,
    output logic              busy
);

    localparam int OW   = (IFM_W + 2*PAD - 3) / STRIDE + 1;
    localparam int OH   = (IFM_H + 2*PAD - 3) / STRIDE + 1;
    localparam int NPIX = IFM_W * IFM_H;
    localparam int PCW  = $clog2(NPIX + 1);
    localparam int PAW  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int OXW  = $clog2(OW + 1);
    localparam int OYW  = $clog2(OH + 1);
    localparam int PW   = 2*DW;
    // Sign bit fed into every extension; zero in unsigned mode.
    localparam bit SG   = (SIGNED != 0);

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   wgt [9];
    logic [3:0]      wcnt;
    logic [DW-1:0]   pix [NPIX];
    logic [PCW-1:0]  pcnt;
    logic [OXW-1:0]  ox;
    logic [OYW-1:0]  oy;
    logic [2:0]      dcnt;

    logic            w_acc, p_acc, loaded, last_win, drain_done;

    assign in_ready   = (state == LOAD) && (pcnt < PCW'(NPIX));
    assign busy       = (state != LOAD);
    assign w_acc      = (state == LOAD) && weight_valid && (wcnt < 4'd9);
    assign p_acc      = in_valid && in_ready;
    assign loaded     = (wcnt == 4'd9) && (pcnt == PCW'(NPIX));
    assign last_win   = (ox == OXW'(OW - 1)) && (oy == OYW'(OH - 1));
    assign drain_done = (dcnt == 3'd4);

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (loaded)     state_nxt = COMPUTE;
            COMPUTE: if (last_win)   state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = LOAD;
            default:                 state_nxt = LOAD;
        endcase
    end

    // Counters: beat counts, window position and drain timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
            pcnt <= '0;
            ox   <= '0;
            oy   <= '0;
            dcnt <= '0;
        end else begin
            if (w_acc) wcnt <= wcnt + 4'd1;
            if (p_acc) pcnt <= pcnt + 1'b1;
            if (state == COMPUTE) begin
                if (last_win) begin
                    ox <= '0;
                    oy <= '0;
                end else if (ox == OXW'(OW - 1)) begin
                    ox <= '0;
                    oy <= oy + 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
            end
            if (state == DRAIN) begin
                if (drain_done) begin
                    dcnt <= '0;
                    wcnt <= '0;
                    pcnt <= '0;
                end else begin
                    dcnt <= dcnt + 3'd1;
                end
            end
        end
    end

    // Weight and frame storage carry no reset; the counts gate every use.
    always_ff @(posedge clk) begin
        if (w_acc) wgt[wcnt]        <= In_Weight_1;
        if (p_acc) pix[PAW'(pcnt)]  <= In_IFM_1;
    end

    // Window gather: taps falling in the padding ring read as zero.
    logic [DW-1:0] tap [9];
    always_comb begin
        int r, c;
        r = 0;
        c = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r = int'(oy) * STRIDE - PAD + i;
                c = int'(ox) * STRIDE - PAD + j;
                tap[i*3+j] = '0;
                if (r >= 0 && r < IFM_H && c >= 0 && c < IFM_W)
                    tap[i*3+j] = pix[PAW'(r*IFM_W + c)];
            end
        end
    end

    // Operands are extended to product width so a plain multiply yields
    // the correct low 2*DW bits in either signedness.
    logic [PW-1:0] prod [9];
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod[k] = {{DW{SG & tap[k][DW-1]}}, tap[k]} * {{DW{SG & wgt[k][DW-1]}}, wgt[k]};
        end
    end

    logic [PW-1:0]   p1 [9];
    logic [PW:0]     s2 [5];
    logic [PW+1:0]   s3 [3];
    logic [PW+2:0]   s4 [2];
    logic [4:1]      vld;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 9; k++) p1[k] <= prod[k];
        for (int k = 0; k < 4; k++)
            s2[k] <= {SG & p1[2*k][PW-1], p1[2*k]} + {SG & p1[2*k+1][PW-1], p1[2*k+1]};
        s2[4] <= {SG & p1[8][PW-1], p1[8]};
        s3[0] <= {SG & s2[0][PW], s2[0]} + {SG & s2[1][PW], s2[1]};
        s3[1] <= {SG & s2[2][PW], s2[2]} + {SG & s2[3][PW], s2[3]};
        s3[2] <= {SG & s2[4][PW], s2[4]};
        s4[0] <= {SG & s3[0][PW+1], s3[0]} + {SG & s3[1][PW+1], s3[1]};
        s4[1] <= {SG & s3[2][PW+1], s3[2]};
    end

    // Valid chain and output register are reset so a mid-frame reset
    // discards everything still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            out_valid <= 1'b0;
            Out_OFM   <= '0;
        end else begin
            vld       <= {vld[3:1], state == COMPUTE};
            out_valid <= vld[4];
            if (vld[4])
                Out_OFM <= {SG & s4[0][PW+2], s4[0]} + {SG & s4[1][PW+2], s4[1]};
            else
                Out_OFM <= '0;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_param.sv
module tb_conv3x3_stream_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [4];
    logic        wv  [4];
    logic        iv  [4];
    logic [15:0] wd  [4];
    logic [15:0] id  [4];
    logic        ir  [4];
    logic        ov  [4];
    logic        bz  [4];
    logic [35:0] oo  [4];

    // Per-instance configuration, mirrored from the instance parameters.
    int p_iw [4] = '{7, 7, 7, 5};
    int p_ih [4] = '{7, 7, 7, 4};
    int p_st [4] = '{1, 1, 2, 2};
    int p_pd [4] = '{0, 1, 0, 1};
    int p_sg [4] = '{0, 0, 1, 1};

    conv3x3_stream_param #(.DW(16), .IFM_W(7), .IFM_H(7), .STRIDE(1), .PAD(0), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst[0]), .weight_valid(wv[0]), .In_Weight_1(wd[0]),
        .in_valid(iv[0]), .In_IFM_1(id[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .Out_OFM(oo[0]), .busy(bz[0]));
    conv3x3_stream_param #(.DW(16), .IFM_W(7), .IFM_H(7), .STRIDE(1), .PAD(1), .SIGNED(0)) u1 (
        .clk(clk), .rst(rst[1]), .weight_valid(wv[1]), .In_Weight_1(wd[1]),
        .in_valid(iv[1]), .In_IFM_1(id[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .Out_OFM(oo[1]), .busy(bz[1]));
    conv3x3_stream_param #(.DW(16), .IFM_W(7), .IFM_H(7), .STRIDE(2), .PAD(0), .SIGNED(1)) u2 (
        .clk(clk), .rst(rst[2]), .weight_valid(wv[2]), .In_Weight_1(wd[2]),
        .in_valid(iv[2]), .In_IFM_1(id[2]), .in_ready(ir[2]),
        .out_valid(ov[2]), .Out_OFM(oo[2]), .busy(bz[2]));
    conv3x3_stream_param #(.DW(16), .IFM_W(5), .IFM_H(4), .STRIDE(2), .PAD(1), .SIGNED(1)) u3 (
        .clk(clk), .rst(rst[3]), .weight_valid(wv[3]), .In_Weight_1(wd[3]),
        .in_valid(iv[3]), .In_IFM_1(id[3]), .in_ready(ir[3]),
        .out_valid(ov[3]), .Out_OFM(oo[3]), .busy(bz[3]));

    int          n_pass  = 0;
    int          n_total = 0;
    int          act     = 0;
    bit          started = 1'b0;
    logic [15:0] wts [9];
    logic [15:0] pix [49];
    logic [35:0] exp_q [$];

    task automatic check(input bit ok, input string name, input longint got, input longint want);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    function automatic longint opval(input logic [15:0] x, input int sg);
        if (sg != 0) return longint'($signed(x));
        return longint'(x);
    endfunction

    // Reference: direct definition of the strided, zero-padded 3x3 correlation.
    task automatic build_expected(input int d);
        int ow, oh, r, c;
        longint s;
        ow = (p_iw[d] + 2*p_pd[d] - 3) / p_st[d] + 1;
        oh = (p_ih[d] + 2*p_pd[d] - 3) / p_st[d] + 1;
        exp_q.delete();
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                s = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        r = oy*p_st[d] - p_pd[d] + i;
                        c = ox*p_st[d] - p_pd[d] + j;
                        if (r >= 0 && r < p_ih[d] && c >= 0 && c < p_iw[d])
                            s += opval(wts[i*3+j], p_sg[d]) * opval(pix[r*p_iw[d]+c], p_sg[d]);
                    end
                end
                exp_q.push_back(36'(s));
            end
        end
    endtask

    // Output checker: every active result is matched against the model;
    // idle outputs must read as zero.
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 4; d++) begin
                if (ov[d]) begin
                    if (d == act && exp_q.size() != 0) begin
                        logic [35:0] e;
                        e = exp_q.pop_front();
                        check(oo[d] == e, "ofm", oo[d], e);
                    end else begin
                        check(1'b0 == ov[d], "unexpected_out_valid", ov[d], 0);
                    end
                end else begin
                    check(oo[d] == 36'd0, "ofm_idle_zero", oo[d], 0);
                end
            end
        end
    end

    task automatic tick(input int d, input bit junk);
        @(posedge clk);
        #1;
        if (junk) begin
            if (bz[d]) begin
                iv[d] = 1'b1;
                id[d] = 16'($urandom);
                check(ir[d] == 1'b0, "in_ready_while_busy", ir[d], 0);
            end else begin
                iv[d] = 1'b0;
            end
        end
    endtask

    task automatic load_frame(input int d, input bit gaps);
        int  wi, pi, npix;
        bit  ws, ps, pacc;
        wi = 0;
        pi = 0;
        npix = p_iw[d] * p_ih[d];
        while (wi < 9 || pi < npix) begin
            ws = (!gaps) || ($urandom_range(0, 3) != 0);
            ps = (pi < npix) && ((!gaps) || ($urandom_range(0, 2) != 0));
            wv[d] = ws;
            wd[d] = (wi < 9) ? wts[wi] : 16'hDEAD;   // extra beats must be dropped
            iv[d] = ps;
            id[d] = ps ? pix[pi] : 16'($urandom);
            pacc  = ps && ir[d];
            if (ps) check(ir[d] == 1'b1, "in_ready_during_load", ir[d], 1);
            @(posedge clk);
            #1;
            if (ws && wi < 9) wi++;
            if (pacc) pi++;
        end
        wv[d] = 1'b0;
        iv[d] = 1'b0;
    endtask

    task automatic run_frame(input int d, input bit gaps, input bit junk);
        int n, len, nexp;
        act  = d;
        nexp = exp_q.size();
        load_frame(d, gaps);
        check(ir[d] == 1'b0, "in_ready_frame_full", ir[d], 0);
        n = 0;
        while (!bz[d] && n < 50) begin tick(d, junk); n++; end
        check(n == 1, "compute_entry_delay", n, 1);
        n = 0;
        while (!ov[d] && n < 50) begin tick(d, junk); n++; end
        check(n == 5, "first_result_latency", n, 5);
        len = 0;
        while (ov[d] && len < 300) begin
            check(bz[d] == 1'b1, "busy_during_results", bz[d], 1);
            len++;
            tick(d, junk);
        end
        check(len == nexp, "result_run_length", len, nexp);
        check(bz[d] == 1'b0, "busy_after_drain", bz[d], 0);
        check(ir[d] == 1'b1, "in_ready_after_drain", ir[d], 1);
        check(exp_q.size() == 0, "results_outstanding", exp_q.size(), 0);
        iv[d] = 1'b0;
    endtask

    task automatic run_reset_mid(input int d);
        int n, cnt;
        act = d;
        load_frame(d, 1'b0);
        n = 0;
        while (!ov[d] && n < 60) begin tick(d, 1'b0); n++; end
        check(ov[d] == 1'b1, "reset_run_started", ov[d], 1);
        cnt = 1;
        n = 0;
        while (cnt < 3 && n < 20) begin
            tick(d, 1'b0);
            if (ov[d]) cnt++;
            n++;
        end
        rst[d] = 1'b1;
        tick(d, 1'b0);
        rst[d] = 1'b0;
        exp_q.delete();
        check(ov[d] == 1'b0, "out_valid_after_reset", ov[d], 0);
        check(bz[d] == 1'b0, "busy_after_reset", bz[d], 0);
        check(ir[d] == 1'b1, "in_ready_after_reset", ir[d], 1);
    endtask

    task automatic fill(input logic [15:0] wval, input logic [15:0] pval);
        for (int k = 0; k < 9; k++)  wts[k] = wval;
        for (int k = 0; k < 49; k++) pix[k] = pval;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 4; d++) begin
            rst[d] = 1'b1; wv[d] = 1'b0; iv[d] = 1'b0; wd[d] = '0; id[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check(ov[d] == 1'b0, "reset_out_valid", ov[d], 0);
            check(oo[d] == 36'd0, "reset_ofm", oo[d], 0);
            check(bz[d] == 1'b0, "reset_busy", bz[d], 0);
            check(ir[d] == 1'b1, "reset_in_ready", ir[d], 1);
            rst[d] = 1'b0;
        end
        started = 1'b1;

        // All-ones frame: every window sums to 9.
        fill(16'd1, 16'd1);
        build_expected(0);
        check(exp_q.size() == 25, "model_s1_count", exp_q.size(), 25);
        check(exp_q[0] == 36'd9, "model_s1_value", exp_q[0], 9);
        run_frame(0, 1'b0, 1'b0);

        // Centre tap only: output is the shifted ramp.
        fill(16'd0, 16'd0);
        wts[4] = 16'd1;
        for (int k = 0; k < 49; k++) pix[k] = 16'(k);
        build_expected(0);
        check(exp_q[0] == 36'd8,  "model_s2_o0", exp_q[0], 8);
        check(exp_q[4] == 36'd12, "model_s2_o4", exp_q[4], 12);
        check(exp_q[5] == 36'd15, "model_s2_o5", exp_q[5], 15);
        check(exp_q[24] == 36'd40, "model_s2_o24", exp_q[24], 40);
        run_frame(0, 1'b1, 1'b0);

        // Full-scale unsigned operands.
        fill(16'hFFFF, 16'hFFFF);
        build_expected(0);
        check(exp_q[0] == 36'h8FFEE0009, "model_s3_value", exp_q[0], 36'h8FFEE0009);
        run_frame(0, 1'b1, 1'b0);

        // Padded frame: corner, edge, interior sums.
        fill(16'd1, 16'd1);
        build_expected(1);
        check(exp_q.size() == 49, "model_s4_count", exp_q.size(), 49);
        check(exp_q[0] == 36'd4, "model_s4_corner", exp_q[0], 4);
        check(exp_q[1] == 36'd6, "model_s4_edge", exp_q[1], 6);
        check(exp_q[8] == 36'd9, "model_s4_interior", exp_q[8], 9);
        run_frame(1, 1'b0, 1'b0);

        // Signed stride-2 with in_valid held high while busy.
        fill(16'hFFFF, 16'd2);
        build_expected(2);
        check(exp_q.size() == 9, "model_s5_count", exp_q.size(), 9);
        check(exp_q[0] == 36'hFFFFFFFEE, "model_s5_value", exp_q[0], 36'hFFFFFFFEE);
        run_frame(2, 1'b0, 1'b1);

        // Randomised frames on every configuration, with random beat gaps.
        for (int rep = 0; rep < 2; rep++) begin
            for (int d = 0; d < 4; d++) begin
                for (int k = 0; k < 9; k++)  wts[k] = 16'($urandom);
                for (int k = 0; k < 49; k++) pix[k] = 16'($urandom);
                build_expected(d);
                run_frame(d, 1'b1, rep == 1);
            end
        end

        // Reset during the result stream, then a clean reload.
        fill(16'd1, 16'd1);
        build_expected(0);
        run_reset_mid(0);
        build_expected(0);
        check(exp_q[24] == 36'd9, "model_s6_value", exp_q[24], 9);
        run_frame(0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
